// File: rtl/sevenseg_scan_driver_if.sv
// sevenseg_scan_driver_if: digit load bus and scanned display outputs of the 7-segment driver.
interface sevenseg_scan_driver_if;
   logic       load;
   logic [3:0] d3;
   logic [3:0] d2;
   logic [3:0] d1;
   logic [3:0] d0;
   logic [3:0] dp_in;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_done;
   modport master (output load, d3, d2, d1, d0, dp_in, input an, seg, dp, frame_done);
   modport slave (input load, d3, d2, d1, d0, dp_in, output an, seg, dp, frame_done);
endinterface

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: 4-digit multiplexed 7-segment driver with frame-aligned digit updates.
// Optional SEVENSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module sevenseg_scan_driver #(
   parameter int SCAN_DIV = 50000,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic rst,
   sevenseg_scan_driver_if.slave bus
);
   logic [CNT_W-1:0] cnt;
   logic [1:0] idx;
   logic [3:0][3:0] din, pend, disp;
   logic [3:0] pend_dp, disp_dp, cur;
   logic pend_flag, tick, boundary, blank;
   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0: decode = 7'b1000000;
         4'd1: decode = 7'b1111001;
         4'd2: decode = 7'b0100100;
         4'd3: decode = 7'b0110000;
         4'd4: decode = 7'b0011001;
         4'd5: decode = 7'b0010010;
         4'd6: decode = 7'b0000010;
         4'd7: decode = 7'b1111000;
         4'd8: decode = 7'b0000000;
         4'd9: decode = 7'b0010000;
         default: decode = 7'b0111111;
      endcase
   endfunction
   assign din = {bus.d3, bus.d2, bus.d1, bus.d0};
   assign tick = cnt == CNT_W'(SCAN_DIV - 1);
   assign boundary = tick && idx == 2'd3;
   assign cur = disp[idx];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
   always_comb blank = idx == 2'd3 ? disp[3] == '0 :
                       idx == 2'd2 ? disp[3:2] == '0 :
                       idx == 2'd1 ? disp[3:1] == '0 : 1'b0;
`else
   assign blank = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         pend <= '0;
         disp <= '0;
         pend_dp <= '0;
         disp_dp <= '0;
         pend_flag <= 1'b0;
         bus.an <= 4'b1111;
         bus.seg <= 7'b1111111;
         bus.dp <= 1'b1;
         bus.frame_done <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         idx <= tick ? idx + 2'd1 : idx;
         bus.frame_done <= boundary;
         // a load landing on the boundary bypasses pending so it is not delayed a frame
         if (boundary) begin
            disp <= bus.load ? din : pend_flag ? pend : disp;
            disp_dp <= bus.load ? bus.dp_in : pend_flag ? pend_dp : disp_dp;
            pend_flag <= 1'b0;
         end else if (bus.load) begin
            pend <= din;
            pend_dp <= bus.dp_in;
            pend_flag <= 1'b1;
         end
         bus.an <= blank ? 4'b1111 : ~(4'b0001 << idx);
         bus.seg <= blank ? 7'b1111111 : decode(cur);
         bus.dp <= blank | ~disp_dp[idx];
      end
   end
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: random loads/resets checked against a frame-level reference model via a scoreboard.
module tb_sevenseg_scan_driver;
   localparam int D = 4;
   localparam int F = 4 * D;
   localparam logic [6:0] LUT [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                       7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
   typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; logic fd; } exp_t;
   typedef struct { int k; logic [15:0] d; logic [3:0] p; } ld_t;
   logic clk = 1'b0;
   logic rst;
   int total = 0;
   int bad = 0;
   int k = 0;
   exp_t q[$];
   ld_t lq[$];
   sevenseg_scan_driver_if bus();
   sevenseg_scan_driver #(.SCAN_DIV(D), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // edge k after reset release shows slot (k/D)%4 of whatever was loaded by the last completed frame
   function automatic exp_t model(input int kk);
      exp_t e;
      logic [15:0] dd = '0;
      logic [3:0] dpp = '0;
      logic [3:0] dig;
      logic blank = 1'b0;
      int slot = (kk / D) % 4;
      int m = kk / F;
      for (int i = 0; i < lq.size(); i++)
         if (m > 0 && lq[i].k <= m * F - 1) begin
            dd = lq[i].d;
            dpp = lq[i].p;
         end
      dig = dd[slot*4 +: 4];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      blank = slot > 0 && (dd >> (slot * 4)) == 16'd0;
`endif
      e.an = blank ? 4'hf : ~(4'(1 << slot));
      e.seg = blank ? 7'h7f : LUT[dig];
      e.dp = blank | ~dpp[slot];
      e.fd = kk % F == F - 1;
      return e;
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         k = 0;
         lq.delete();
         q.push_back('{4'hf, 7'h7f, 1'b1, 1'b0});
      end else begin
         if (bus.load) lq.push_back('{k, {bus.d3, bus.d2, bus.d1, bus.d0}, bus.dp_in});
         q.push_back(model(k));
         k++;
      end
   end
   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("an", int'(bus.an), int'(e.an));
         chk("seg", int'(bus.seg), int'(e.seg));
         chk("dp", int'(bus.dp), int'(e.dp));
         chk("frame_done", int'(bus.frame_done), int'(e.fd));
      end
   end
   task automatic cyc(input logic r, input logic l, input logic [15:0] d, input logic [3:0] p);
      @(negedge clk);
      rst = r;
      bus.load = l;
      {bus.d3, bus.d2, bus.d1, bus.d0} = d;
      bus.dp_in = p;
   endtask
   function automatic logic [15:0] rnd_digits();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) v[i*4 +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
      return v;
   endfunction
   logic [15:0] tbl_d [6] = '{16'h0125, 16'h0007, 16'h0009, 16'h000C, 16'h0000, 16'h0042};
   logic [3:0] tbl_p [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
   int tbl_gap [6] = '{20, 2, 20, 36, 36, 36};
   initial begin
      rst = 1'b1;
      bus.load = 1'b0;
      {bus.d3, bus.d2, bus.d1, bus.d0} = '0;
      bus.dp_in = '0;
      repeat (3) cyc(1, 0, 0, 0);
      repeat (40) cyc(0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         repeat (5) cyc(0, 0, 0, 0);
         cyc(0, 1, tbl_d[i], tbl_p[i]);
         repeat (tbl_gap[i]) cyc(0, 0, 0, 0);
      end
      for (int i = 0; i < 8; i++) begin
         while (k % F != F - 1) cyc(0, 0, 0, 0);
         cyc(0, 1, i == 0 ? 16'h0042 : rnd_digits(), 4'($urandom_range(0, 15)));
         repeat ($urandom_range(10, 30)) cyc(0, 0, 0, 0);
      end
      for (int i = 0; i < 1500; i++) begin
         if (i == 700 || i == 1200) repeat ($urandom_range(1, 3)) cyc(1, $urandom_range(0, 1), rnd_digits(), 4'hf);
         else cyc(0, $urandom_range(0, 5) == 0, rnd_digits(), 4'($urandom_range(0, 15)));
      end
      repeat (40) cyc(0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      if (total == 0) begin
         bad++;
         $display("FAIL scoreboard got=0 comparisons exp=nonzero");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
